// File: rtl/sequential_left_shifter_if.sv
// Handshake and operand bus between ALU control (master) and the sequential left shifter (slave).
interface sequential_left_shifter_if #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 5
);
   logic              start;
   logic [WIDTH-1:0]  data;
   logic [STAGES-1:0] shamt;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  out;

   modport master (
      output start, data, shamt,
      input  busy, done, out
   );

   modport slave (
      input  start, data, shamt,
      output busy, done, out
   );
endinterface

// File: rtl/sequential_left_shifter.sv
// Multi-cycle 32-bit logical left shifter: one binary stage (16,8,4,2,1) per cycle through a
// shared datapath, fixed 6-cycle operation with start/done handshake and a held registered result.
module sequential_left_shifter #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 5
) (
   input  logic                       clock,
   input  logic                       reset,
   sequential_left_shifter_if.slave   bus
);
   localparam int SW = $clog2(STAGES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [WIDTH-1:0]  work_r, work_nxt_s;
   logic [STAGES-1:0] amt_r, amt_nxt_s;
   logic [SW-1:0]     stage_r, stage_nxt_s;
   logic [WIDTH-1:0]  out_r, out_nxt_s;
   logic              busy_r;
   logic              done_r;
   logic [WIDTH-1:0]  stage_res_s;

   // Shift by 2**s when enabled; vacated LSBs fill with zero, overflow bits are dropped.
   function automatic logic [WIDTH-1:0] stage_shift(
      input logic [WIDTH-1:0] w,
      input logic [SW-1:0]    s,
      input logic             en
   );
      logic [WIDTH-1:0] r;
      if (en) begin
         case (s)
            3'd4:    r = {w[WIDTH-17:0], 16'h0000};
            3'd3:    r = {w[WIDTH-9:0],  8'h00};
            3'd2:    r = {w[WIDTH-5:0],  4'h0};
            3'd1:    r = {w[WIDTH-3:0],  2'b00};
            3'd0:    r = {w[WIDTH-2:0],  1'b0};
            default: r = w;
         endcase
      end else begin
         r = w;
      end
      return r;
   endfunction

   // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
   always_comb begin
      state_nxt_s = state_r;
      work_nxt_s  = work_r;
      amt_nxt_s   = amt_r;
      stage_nxt_s = stage_r;
      out_nxt_s   = out_r;
      stage_res_s = stage_shift(work_r, stage_r, amt_r[stage_r]);
      case (state_r)
         IDLE, DONE: begin
            // DONE accepts a new request exactly like IDLE so back-to-back ops lose no cycle.
            if (bus.start) begin
               work_nxt_s  = bus.data;
               amt_nxt_s   = bus.shamt;
               stage_nxt_s = SW'(STAGES - 1);
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            work_nxt_s = stage_res_s;
            if (stage_r == {SW{1'b0}}) begin
               out_nxt_s   = stage_res_s;
               state_nxt_s = DONE;
            end else begin
               stage_nxt_s = stage_r - {{(SW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, datapath and output registers; reset discards any in-flight operation.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         work_r  <= {WIDTH{1'b0}};
         amt_r   <= {STAGES{1'b0}};
         stage_r <= {SW{1'b0}};
         out_r   <= {WIDTH{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         work_r  <= work_nxt_s;
         amt_r   <= amt_nxt_s;
         stage_r <= stage_nxt_s;
         out_r   <= out_nxt_s;
         busy_r  <= (state_nxt_s == SHIFT);
         done_r  <= (state_nxt_s == DONE);
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.out  = out_r;
endmodule

// File: tb/tb_sequential_left_shifter.sv
// Directed self-checking bench for sequential_left_shifter with hand-computed expected results.
module tb_sequential_left_shifter;
   logic clock;
   logic reset;
   int   checks;
   int   errors;

   sequential_left_shifter_if #(.WIDTH(32), .STAGES(5)) bus ();

   sequential_left_shifter #(.WIDTH(32), .STAGES(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request and let the accepting edge E0 pass.
   task automatic issue(input logic [31:0] d, input logic [4:0] s);
      bus.start = 1'b1;
      bus.data  = d;
      bus.shamt = s;
      tick();
      bus.start = 1'b0;
      bus.data  = 32'h5A5A_5A5A;
      bus.shamt = 5'd7;
   endtask

   // From just after E0: five busy cycles showing the old out, then the DONE cycle.
   task automatic wait_result(input string tag, input logic [31:0] prev, input logic [31:0] exp,
                              input bit noise);
      for (int i = 0; i < 5; i++) begin
         chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
         chk({tag, "_nodone"}, {31'd0, bus.done}, 32'd0);
         chk({tag, "_hold"}, bus.out, prev);
         if (noise) begin
            bus.start = 1'b1;
            bus.data  = 32'hAAAA_AAAA;
            bus.shamt = 5'd1;
         end else begin
            bus.start = 1'b0;
         end
         tick();
      end
      bus.start = 1'b0;
      chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
      chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_out"}, bus.out, exp);
   endtask

   task automatic after_done(input string tag, input logic [31:0] exp);
      tick();
      chk({tag, "_done_fall"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_no_restart"}, {31'd0, bus.busy}, 32'd0);
      chk({tag, "_out_held"}, bus.out, exp);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.data  = 32'h0;
      bus.shamt = 5'd0;

      // 1. asynchronous reset between edges, then idle
      #7 reset = 1'b1;
      #1;
      chk("rst_out", bus.out, 32'h0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_out", bus.out, 32'h0);
         chk("idle_busy", {31'd0, bus.busy}, 32'd0);
         chk("idle_done", {31'd0, bus.done}, 32'd0);
      end

      // 2. basic shifts
      issue(32'h0000_0001, 5'd31);
      wait_result("s31", 32'h0, 32'h8000_0000, 1'b0);
      after_done("s31", 32'h8000_0000);

      issue(32'hDEAD_BEEF, 5'd4);
      wait_result("s4", 32'h8000_0000, 32'hEADB_EEF0, 1'b0);
      after_done("s4", 32'hEADB_EEF0);

      issue(32'hFFFF_FFFF, 5'd2);
      wait_result("s2", 32'hEADB_EEF0, 32'hFFFF_FFFC, 1'b0);
      after_done("s2", 32'hFFFF_FFFC);

      // 3. zero shift keeps the same latency
      issue(32'h1234_5678, 5'd0);
      wait_result("s0", 32'hFFFF_FFFC, 32'h1234_5678, 1'b0);
      after_done("s0", 32'h1234_5678);

      // 4. start and input changes during SHIFT are ignored
      issue(32'h0000_00FF, 5'd8);
      wait_result("ign", 32'h1234_5678, 32'h0000_FF00, 1'b1);
      after_done("ign", 32'h0000_FF00);
      tick();
      chk("ign_single_done", {31'd0, bus.done}, 32'd0);

      // 5. back-to-back: second start in the DONE cycle
      issue(32'h0000_0003, 5'd4);
      wait_result("b2b1", 32'h0000_FF00, 32'h0000_0030, 1'b0);
      issue(32'h8000_0001, 5'd1);
      chk("b2b_done_fall", {31'd0, bus.done}, 32'd0);
      wait_result("b2b2", 32'h0000_0030, 32'h0000_0002, 1'b0);
      after_done("b2b2", 32'h0000_0002);

      // 6. reset during stage 2
      issue(32'h0000_0001, 5'd16);
      tick();
      tick();
      chk("mid_busy", {31'd0, bus.busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_out", bus.out, 32'h0);
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("mid_no_done", {31'd0, bus.done}, 32'd0);
         chk("mid_out_zero", bus.out, 32'h0);
      end
      issue(32'h0000_0001, 5'd16);
      wait_result("post", 32'h0, 32'h0001_0000, 1'b0);
      after_done("post", 32'h0001_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sequential_left_shifter.md
Name: sequential_left_shifter

Overview:
Multi-cycle 32-bit logical left shifter. It is the left-direction counterpart to the fixed right-shift stages in the ALU datapath. Shift amount 0-31 is applied one binary stage per cycle (16, 8, 4, 2, 1) through a single shared datapath, with a start/done handshake to the ALU control. The registered result is held until the next operation completes.

Parameters:
WIDTH, 32, data width in bits; must be 32 in this release (5 stages fixed).
STAGES, 5, number of binary shift stages; equals log2(WIDTH).

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
data  input  32  operand; captured on the accepted start edge.
shamt  input  5  shift amount; captured on the accepted start edge.
busy  output  1  high while a shift is in progress.
done  output  1  one-cycle pulse; out is valid and updated.
out  output  32  registered result; holds its value between operations.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, out=32'h0; working reg, captured shamt and stage counter cleared. Takes effect immediately, including mid-operation. The in-flight result is discarded and no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. On a clock edge with start=1: work<=data, amt<=shamt, stage<=4, go to SHIFT.
- SHIFT: busy=1.
  - Each edge: if amt[stage]=1 then work<=work<<(1<<stage), else work unchanged. Vacated LSBs are filled with 0 and bits shifted past bit 31 are lost.
  - stage 4 down to 1: decrement stage, stay in SHIFT.
  - stage 0: out<=final stage-0 result, go to DONE.
- DONE: busy=0, done=1 for exactly this one cycle.
  - start=1 on this edge: accepted exactly as from IDLE, go to SHIFT; done falls next cycle.
  - Otherwise go to IDLE.
- Latency is fixed regardless of shamt, including shamt=0:
  - start sampled at edge E0.
  - Stages 4..0 execute at edges E1..E5.
  - out is updated and done is high in the cycle following E5.
  - Throughput is one operation per 6 cycles.
- start while busy=1 is ignored: no queueing, no effect on the current operation.
- data and shamt are don't-care except on the accepting edge. Changes during SHIFT must not affect the result.
- out changes only on the stage-0 edge. During a new operation it still shows the previous result.
- Result equals data<<shamt, truncated to 32 bits. shamt=0 gives data unchanged, bit-exact.
- No X on outputs after reset; all registers are explicitly reset.

Test Plan:
1. Reset then idle: assert reset asynchronously between edges -> out=0, busy=0, done=0 immediately; with start=0 for 20 cycles, outputs stay constant.
2. Basic shifts:
   - data=32'h0000_0001, shamt=31 -> done 5 edges after accept, out=32'h8000_0000.
   - data=32'hDEAD_BEEF, shamt=4 -> out=32'hEADB_EEF0.
   - data=32'hFFFF_FFFF, shamt=2 -> out=32'hFFFF_FFFC.
3. Zero shift and latency: data=32'h1234_5678, shamt=0 -> out=32'h1234_5678. busy high for exactly 5 cycles, done high for exactly 1 cycle, same latency as shamt=31.
4. Ignored start and input changes: start a shift with data=32'h0000_00FF, shamt=8. During SHIFT, pulse start with data=32'hAAAA_AAAA, shamt=1 -> out=32'h0000_FF00, only one done pulse, old out is visible until done.
5. Back-to-back: assert start in the DONE cycle with data=32'h8000_0001, shamt=1 -> first result is delivered. The second op is accepted with no IDLE cycle, yielding out=32'h0000_0002 six cycles later.
6. Reset mid-operation: assert reset at stage 2 of a shift with data=32'h1, shamt=16 -> out=0, no done pulse. After release, a new op with data=32'h1, shamt=16 -> out=32'h0001_0000.
